// File: rtl/clock_set_ctrl.sv
// Purpose: turns the raw mode/advance pushbuttons into clock and alarm set controls with auto-repeat and an idle timeout.
// Latency: a button sampled at clk edge k is visible on mode/timeset/alarmset/hrsadv/minadv after edge k (Moore, registered).
// Backpressure: none; the buttons are sampled every clk cycle and the advance pulses are one cycle wide and cannot be stalled.
module clock_set_ctrl #(
  parameter int HOLD    = 3,
  parameter int TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       adv_btn,
  output logic       timeset,
  output logic       alarmset,
  output logic       hrsadv,
  output logic       minadv,
  output logic [2:0] mode
);

  localparam int HC_W   = $clog2(HOLD + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_TH = 3'd1,
    SET_TM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic                adv_q, adv_d;
  logic                lockout_q, lockout_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                hrsadv_q, hrsadv_d;
  logic                minadv_q, minadv_d;

  logic                mode_edge;
  logic                in_set;
  logic                pulse;

  // Button history: previous samples used for edge detection on both buttons.
  always_comb begin
    mode_d    = mode_btn;
    adv_d     = adv_btn;
    mode_edge = mode_btn & ~mode_q;
    in_set    = (state_q != RUN);
  end

  // Next-state logic: mode edges step through the ring, an idle run in a set state falls back to RUN.
  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    if (mode_edge) begin
      case (state_q)
        RUN:     state_d = SET_TH;
        SET_TH:  state_d = SET_TM;
        SET_TM:  state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        SET_AM:  state_d = RUN;
        default: state_d = RUN;
      endcase
    end else if (in_set && !mode_btn && !adv_btn) begin
      // idle_q never reaches TIMEOUT: the sample that would make it so is the one that leaves.
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d = RUN;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  // Advance generation: pulse on press, then auto-repeat once the hold counter saturates at HOLD.
  always_comb begin
    pulse     = 1'b0;
    hc_d      = hc_q;
    lockout_d = lockout_q;
    if (!adv_btn) begin
      // Releasing the button clears both the hold count and any lockout.
      hc_d      = '0;
      lockout_d = 1'b0;
    end else if (mode_edge) begin
      // Mode edge wins; the advance stays locked out until the button is released.
      hc_d      = '0;
      lockout_d = 1'b1;
    end else if (!in_set || lockout_q) begin
      hc_d = '0;
    end else if (!adv_q) begin
      pulse = 1'b1;
      hc_d  = HC_W'(1);
    end else if (hc_q < HC_W'(HOLD)) begin
      hc_d = hc_q + HC_W'(1);
    end else begin
      pulse = 1'b1;
    end
  end

  // Route the pulse to the hours or minutes line; the state cannot change on a pulse sample.
  always_comb begin
    hrsadv_d = pulse & ((state_q == SET_TH) | (state_q == SET_AH));
    minadv_d = pulse & ((state_q == SET_TM) | (state_q == SET_AM));
  end

  // State and counter registers; reset discards any hold or idle progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      mode_q    <= 1'b0;
      adv_q     <= 1'b0;
      lockout_q <= 1'b0;
      hc_q      <= '0;
      idle_q    <= '0;
      hrsadv_q  <= 1'b0;
      minadv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      adv_q     <= adv_d;
      lockout_q <= lockout_d;
      hc_q      <= hc_d;
      idle_q    <= idle_d;
      hrsadv_q  <= hrsadv_d;
      minadv_q  <= minadv_d;
    end
  end

  // Output decode straight from registers so downstream counters see glitch-free levels.
  always_comb begin
    mode     = state_q;
    timeset  = (state_q == SET_TH) | (state_q == SET_TM);
    alarmset = (state_q == SET_AH) | (state_q == SET_AM);
    hrsadv   = hrsadv_q;
    minadv   = minadv_q;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Purpose: randomized and directed stimulus for clock_set_ctrl, checked every cycle against a behavioural model.
// Latency: outputs are compared on the falling edge, half a cycle after the sampling edge.
// Backpressure: not applicable; the bench drives buttons freely.
module tb_clock_set_ctrl;

  localparam int HOLD    = 3;
  localparam int TIMEOUT = 10;

  logic       clk;
  logic       rst;
  logic       mode_btn;
  logic       adv_btn;
  logic       timeset;
  logic       alarmset;
  logic       hrsadv;
  logic       minadv;
  logic [2:0] mode;

  int errors;
  int checks;

  clock_set_ctrl #(.HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_btn (mode_btn),
    .adv_btn  (adv_btn),
    .timeset  (timeset),
    .alarmset (alarmset),
    .hrsadv   (hrsadv),
    .minadv   (minadv),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode index on a 5-entry ring, run length of adv presses, idle streak.
  int m_state;
  bit m_prev_mode;
  bit m_locked;
  int m_run;
  int m_idle;
  bit m_hrs;
  bit m_min;
  bit m_edge;
  bit m_pulse;
  int m_next;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_prev_mode = 0; m_locked = 0; m_run = 0; m_idle = 0; m_hrs = 0; m_min = 0;
    end else begin
      m_edge  = mode_btn && !m_prev_mode;
      m_next  = m_edge ? (m_state + 1) % 5 : m_state;
      // Pulse on the first held sample and on every held sample from HOLD onwards.
      m_pulse = (m_state != 0) && !m_edge && adv_btn && !m_locked && (m_run == 0 || m_run >= HOLD);
      if (!adv_btn) m_locked = 0;
      else if (m_edge) m_locked = 1;
      if (m_state != 0 && !mode_btn && !adv_btn) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_next = 0;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
      m_hrs = m_pulse && (m_state == 1 || m_state == 3);
      m_min = m_pulse && (m_state == 2 || m_state == 4);
      m_run = adv_btn ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      m_state     = m_next;
      m_prev_mode = mode_btn;
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    chk("mode",     int'(mode),     m_state);
    chk("timeset",  int'(timeset),  int'(m_state == 1 || m_state == 2));
    chk("alarmset", int'(alarmset), int'(m_state == 3 || m_state == 4));
    chk("hrsadv",   int'(hrsadv),   int'(m_hrs));
    chk("minadv",   int'(minadv),   int'(m_min));
  end

  task automatic step(input logic m, input logic a);
    mode_btn = m;
    adv_btn  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
  endtask

  int exp_mode [5] = '{1, 2, 3, 4, 0};
  int exp_ts   [5] = '{1, 1, 0, 0, 0};
  int exp_as   [5] = '{0, 0, 1, 1, 0};
  logic [6:0] seen;
  int cnt;
  bit adv_lvl;

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    mode_btn = 1'b0;
    adv_btn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mode", int'(mode), 0);
    chk("reset_outs", int'({timeset, alarmset, hrsadv, minadv}), 0);
    rst = 1'b1;

    // Mode cycling through the whole ring.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk("cycle_mode", int'(mode), exp_mode[i]);
      chk("cycle_timeset", int'(timeset), exp_ts[i]);
      chk("cycle_alarmset", int'(alarmset), exp_as[i]);
      step(1'b0, 1'b0);
    end

    // Holding mode advances only once.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("mode_hold_once", int'(mode), 1);
    step(1'b0, 1'b0);

    // Single advance in SET_TM.
    press_mode(1);
    step(1'b0, 1'b1);
    chk("single_minadv", int'(minadv), 1);
    chk("single_hrsadv", int'(hrsadv), 0);
    step(1'b0, 1'b0);
    chk("single_minadv_end", int'(minadv), 0);

    // Auto-repeat in SET_TH: held samples 0,3,4,5,6 pulse.
    press_mode(4);
    chk("in_set_th", int'(mode), 1);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1);
      seen[i] = hrsadv;
    end
    chk("repeat_pattern", int'(seen), int'(7'b1111001));
    step(1'b0, 1'b0);
    chk("repeat_end", int'(hrsadv), 0);

    // Simultaneous mode and advance: mode wins, advance locked until release.
    step(1'b1, 1'b1);
    chk("simul_mode", int'(mode), 2);
    chk("simul_pulse", int'(hrsadv | minadv), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      cnt += int'(minadv);
    end
    chk("simul_locked", cnt, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("simul_after_release", int'(minadv), 1);
    step(1'b0, 1'b0);

    // Timeout in SET_AH, restarted by a press on idle sample 9.
    step(1'b1, 1'b0);
    chk("to_enter", int'(mode), 3);
    repeat (8) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("to_sample9", int'(mode), 3);
    repeat (9) step(1'b0, 1'b0);
    chk("to_not_yet", int'(mode), 3);
    step(1'b0, 1'b0);
    chk("to_expired", int'(mode), 0);

    // Advance ignored in RUN.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 3) != 2);
      cnt += int'(hrsadv) + int'(minadv);
    end
    chk("run_ignore", cnt, 0);
    step(1'b0, 1'b0);

    // Asynchronous reset mid-hold in SET_AM.
    press_mode(4);
    chk("in_set_am", int'(mode), 4);
    repeat (3) step(1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mode", int'(mode), 0);
    chk("arst_outs", int'({timeset, alarmset, hrsadv, minadv}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b1);
    chk("release_no_pulse", int'(hrsadv | minadv), 0);
    step(1'b0, 1'b0);

    // Randomized phase with idle bursts and occasional resets.
    adv_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat (TIMEOUT + 2) step(1'b0, 1'b0);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      if ($urandom_range(0, 99) < 20) adv_lvl = ~adv_lvl;
      step($urandom_range(0, 99) < 12, adv_lvl);
    end
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
